bit_serializer: RTL and testbench
=================================

Name: bit_serializer

Overview:
- Upstream feeder for the serial sequence-detector FSM.
- Accepts a parallel word through a load/ready handshake, then shifts it out one bit per clock on `sout`.
- `sout` drives the detector's `x` input directly.
- Supports gapless back-to-back words, so the detector sees a continuous bitstream across word boundaries (needed for overlapping-pattern detection).

Parameters:
- WIDTH, 8, number of bits per parallel word (legal range 2..32).
- MSB_FIRST, 1, 1 = din[WIDTH-1] is shifted first; 0 = din[0] is shifted first.
- IDLE_BIT, 0, value driven on `sout` when no word is being shifted.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- nrst  input  1  synchronous active-low reset.
- din  input  WIDTH  parallel word to serialize.
- load  input  1  request to capture din; accepted only when load & ready at a rising edge.
- ready  output  1  block can accept a word this cycle.
- sout  output  1  serial bit; connects to detector x.
- sout_valid  output  1  sout carries a data bit this cycle.
- done  output  1  one-cycle pulse coincident with the last bit of a word.

Behaviour:
- Interface: one clock (clk); reset is synchronous and active-low (nrst). Sampled only on the rising edge of clk.
- Reset (nrst=0 at an edge):
  - state=IDLE, shift register=0, bit counter=0.
  - sout=IDLE_BIT, sout_valid=0, done=0.
  - ready is forced 0 while nrst=0; load is ignored.
- States: IDLE, SHIFT. Counter width is $clog2(WIDTH); counter value is the index of the bit currently on sout.
- ready (combinational) = nrst & ((state==IDLE) | (state==SHIFT & cnt==WIDTH-1)).
- IDLE:
  - sout=IDLE_BIT, sout_valid=0.
  - On load&ready: capture din, go to SHIFT, cnt=0.
  - The first bit appears on sout in the cycle after the accepting edge (latency 1).
- SHIFT:
  - sout and sout_valid are registered outputs; sout_valid=1.
  - Each edge: shift the register by one toward the output end and increment cnt.
  - When cnt==WIDTH-1: done=1 this cycle.
  - At the following edge, if load&ready: reload din, cnt=0, stay in SHIFT. The next word's first bit follows the last bit with no gap.
  - At that edge with no load: go to IDLE; sout returns to IDLE_BIT.
- Busy loads: load while ready=0 is ignored and the word is dropped. No buffering; the source must hold load until it sees ready.
- din is sampled only at the accepting edge; later changes to din do not affect the bits in flight.
- Reset mid-word: abort immediately; the next cycle shows reset values, and the partial word is discarded.
- Throughput: one bit per cycle sustained, WIDTH cycles per word.

Decomposition:
- Shared package holds:
  - state encoding constants ST_IDLE=1'b0, ST_SHIFT=1'b1.
  - default WIDTH.
  - a width-helper function for the counter.
- No sub-module; the shift register and counter stay inline. Target roughly 120-160 lines including assertions (ready never 1 during reset; done only when sout_valid).

Test Plan:
- Reset → hold nrst=0 for 2 cycles with load=1, din=8'hFF → sout=0, sout_valid=0, done=0, ready=0; no word accepted after release.
- Single word: din=8'b10101000, MSB_FIRST=1, load for 1 cycle → sout=1,0,1,0,1,0,0,0 on cycles 1..8 after acceptance; done on cycle 8; then idle 0.
- Back-to-back: load 8'hA5 then hold load high with 8'h3C ready at cnt=7 → 16 contiguous valid bits 10100101 00111100; sout_valid never drops; two done pulses 8 cycles apart.
- Busy load: pulse load with din=8'hFF at cnt=3 of word 8'h00 → ignored; output stays eight 0s; no extra word follows.
- Mid-word reset: assert nrst=0 at cnt=4 of word 8'hAA → next cycle sout=0, valid=0; after release, ready=1 and a new load of 8'h81 produces 1,0,0,0,0,0,0,1.
- MSB_FIRST=0, WIDTH=5: din=5'b10101 → sout=1,0,1,0,1. Drive the detector with it and check that the detector output y asserts on the fifth bit.

Source files
------------

// File: rtl/bit_serializer_pkg.sv
// -----------------------------------------------------------------------------
// bit_serializer_pkg
// Shared definitions for the bit serializer.
//   ST_IDLE / ST_SHIFT : state encoding of the serializer FSM
//   DEFAULT_WIDTH      : default number of bits per parallel word
//   cnt_width()        : width of the bit-index counter for a given word width
// -----------------------------------------------------------------------------
package bit_serializer_pkg;

   localparam logic [0:0] ST_IDLE  = 1'b0;
   localparam logic [0:0] ST_SHIFT = 1'b1;

   localparam int DEFAULT_WIDTH = 8;

   // Counter holds indices 0..w-1; never narrower than one bit.
   function automatic int cnt_width(input int w);
      return ($clog2(w) < 1) ? 1 : $clog2(w);
   endfunction

endpackage

// File: rtl/bit_serializer_if.sv
// -----------------------------------------------------------------------------
// bit_serializer_if
// Parallel-load / serial-out bus of the bit serializer.
//   din        : parallel word offered by the source
//   load       : source requests capture of din
//   ready      : serializer can accept a word this cycle
//   sout       : serial bit (feeds the sequence detector x input)
//   sout_valid : sout carries a data bit this cycle
//   done       : pulse coincident with the last bit of a word
// master = word source / bit sink, slave = serializer.
// -----------------------------------------------------------------------------
interface bit_serializer_if
   import bit_serializer_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
) ();

   logic [WIDTH-1:0] din;
   logic             load;
   logic             ready;
   logic             sout;
   logic             sout_valid;
   logic             done;

   modport master (
      output din,
      output load,
      input  ready,
      input  sout,
      input  sout_valid,
      input  done
   );

   modport slave (
      input  din,
      input  load,
      output ready,
      output sout,
      output sout_valid,
      output done
   );

endinterface

// File: rtl/bit_serializer.sv
// -----------------------------------------------------------------------------
// bit_serializer
// Captures a parallel word through a load/ready handshake and shifts it out
// one bit per clock. A new word may be accepted while the last bit of the
// current word is on sout, so consecutive words form a gapless bitstream.
// Ports:
//   clk  : system clock, rising edge
//   nrst : synchronous active-low reset
//   bus  : bit_serializer_if.slave (din, load, ready, sout, sout_valid, done)
// Parameters:
//   WIDTH     : bits per word (2..32)
//   MSB_FIRST : 1 = din[WIDTH-1] leaves first, 0 = din[0] leaves first
//   IDLE_BIT  : level on sout when no word is being shifted
// -----------------------------------------------------------------------------
module bit_serializer
   import bit_serializer_pkg::*;
#(
   parameter int   WIDTH     = DEFAULT_WIDTH,
   parameter bit   MSB_FIRST = 1'b1,
   parameter logic IDLE_BIT  = 1'b0
) (
   input logic             clk,
   input logic             nrst,
   bit_serializer_if.slave bus
);

   localparam int            CW       = cnt_width(WIDTH);
   localparam logic [CW-1:0] LAST_IDX = CW'(WIDTH - 1);

   logic [0:0]       state_q, state_d;
   logic [WIDTH-1:0] shreg_q, shreg_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             sout_q, sout_d;
   logic             valid_q, valid_d;
   logic             last_bit;
   logic             accept;

   // Bit currently at the output end of a shift-register image.
   function automatic logic out_end(input logic [WIDTH-1:0] w);
      return MSB_FIRST ? w[WIDTH-1] : w[0];
   endfunction

   assign last_bit  = (state_q == ST_SHIFT) && (cnt_q == LAST_IDX);
   // Ready during the last bit is what makes back-to-back words gapless.
   assign bus.ready = nrst & ((state_q == ST_IDLE) | last_bit);
   assign accept    = bus.load & bus.ready;

   always_comb begin
      state_d = state_q;
      shreg_d = shreg_q;
      cnt_d   = cnt_q;
      if (accept) begin
         state_d = ST_SHIFT;
         shreg_d = bus.din;
         cnt_d   = '0;
      end else if (state_q == ST_SHIFT) begin
         if (last_bit) begin
            state_d = ST_IDLE;
            shreg_d = '0;
            cnt_d   = '0;
         end else begin
            shreg_d = MSB_FIRST ? {shreg_q[WIDTH-2:0], 1'b0}
                                : {1'b0, shreg_q[WIDTH-1:1]};
            cnt_d   = cnt_q + CW'(1);
         end
      end
      // Outputs are computed from the next state so they come straight
      // out of flops, glitch-free, in the cycle after each edge.
      valid_d = (state_d == ST_SHIFT);
      sout_d  = valid_d ? out_end(shreg_d) : IDLE_BIT;
   end

   always_ff @(posedge clk) begin
      if (!nrst) begin
         state_q <= ST_IDLE;
         shreg_q <= '0;
         cnt_q   <= '0;
         sout_q  <= IDLE_BIT;
         valid_q <= 1'b0;
      end else begin
         state_q <= state_d;
         shreg_q <= shreg_d;
         cnt_q   <= cnt_d;
         sout_q  <= sout_d;
         valid_q <= valid_d;
      end
   end

   assign bus.sout       = sout_q;
   assign bus.sout_valid = valid_q;
   assign bus.done       = last_bit;

   a_no_ready_in_reset : assert property (@(posedge clk) !nrst |-> !bus.ready);
   a_done_only_valid   : assert property (@(posedge clk) disable iff (!nrst)
                                          bus.done |-> bus.sout_valid);

endmodule

// File: tb/tb_bit_serializer.sv
// -----------------------------------------------------------------------------
// tb_bit_serializer
// Two serializers share clk/nrst: dut8 (WIDTH=8, MSB first, idle 0) and
// dut5 (WIDTH=5, LSB first, idle 1). A reference model pushes the expected
// bit stream of every word it considers accepted into a queue at each rising
// edge; a monitor pops one entry per cycle on the falling edge and compares
// sout / sout_valid / done / ready.
// -----------------------------------------------------------------------------
module tb_bit_serializer;

   typedef struct packed {
      logic b;
      logic d;
   } exp_t;

   logic clk;
   logic nrst;
   logic mon_en;
   int   checks;
   int   failures;

   exp_t exp8_q[$];
   exp_t exp5_q[$];

   bit_serializer_if #(.WIDTH(8)) bus8 ();
   bit_serializer_if #(.WIDTH(5)) bus5 ();

   bit_serializer #(.WIDTH(8), .MSB_FIRST(1'b1), .IDLE_BIT(1'b0)) dut8 (
      .clk  (clk),
      .nrst (nrst),
      .bus  (bus8)
   );

   bit_serializer #(.WIDTH(5), .MSB_FIRST(1'b0), .IDLE_BIT(1'b1)) dut5 (
      .clk  (clk),
      .nrst (nrst),
      .bus  (bus5)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic act, input logic exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s t=%0t actual=%b expected=%b", name, $time, act, exp);
      end
   endtask

   // ---------------- reference model ----------------
   // A word is accepted when load is high and no further bits of the previous
   // word are still pending (queue empty = idle or last bit on the line).
   always @(posedge clk) begin
      if (!nrst) begin
         exp8_q.delete();
      end else if (bus8.load && exp8_q.size() == 0) begin
         $display("TXN dut8 accept din=%02h t=%0t", bus8.din, $time);
         for (int i = 0; i < 8; i++)
            exp8_q.push_back('{b: bus8.din[7-i], d: (i == 7)});
      end
   end

   always @(posedge clk) begin
      if (!nrst) begin
         exp5_q.delete();
      end else if (bus5.load && exp5_q.size() == 0) begin
         $display("TXN dut5 accept din=%02h t=%0t", bus5.din, $time);
         for (int i = 0; i < 5; i++)
            exp5_q.push_back('{b: bus5.din[i], d: (i == 4)});
      end
   end

   // ---------------- monitors ----------------
   always @(negedge clk) begin
      if (mon_en) begin
         exp_t e;
         if (exp8_q.size() > 0) begin
            e = exp8_q.pop_front();
            check("dut8_valid", bus8.sout_valid, 1'b1);
            check("dut8_sout",  bus8.sout,       e.b);
            check("dut8_done",  bus8.done,       e.d);
         end else begin
            check("dut8_valid_idle", bus8.sout_valid, 1'b0);
            check("dut8_sout_idle",  bus8.sout,       1'b0);
            check("dut8_done_idle",  bus8.done,       1'b0);
         end
         check("dut8_ready", bus8.ready, nrst && (exp8_q.size() == 0));
      end
   end

   always @(negedge clk) begin
      if (mon_en) begin
         exp_t e;
         if (exp5_q.size() > 0) begin
            e = exp5_q.pop_front();
            check("dut5_valid", bus5.sout_valid, 1'b1);
            check("dut5_sout",  bus5.sout,       e.b);
            check("dut5_done",  bus5.done,       e.d);
         end else begin
            check("dut5_valid_idle", bus5.sout_valid, 1'b0);
            check("dut5_sout_idle",  bus5.sout,       1'b1);
            check("dut5_done_idle",  bus5.done,       1'b0);
         end
         check("dut5_ready", bus5.ready, nrst && (exp5_q.size() == 0));
      end
   end

   // ---------------- stimulus ----------------
   task automatic drive(input logic n, input logic l8, input logic [7:0] d8,
                        input logic l5, input logic [4:0] d5);
      nrst     = n;
      bus8.load = l8;
      bus8.din  = d8;
      bus5.load = l5;
      bus5.din  = d5;
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      repeat (n) drive(1'b1, 1'b0, 8'h00, 1'b0, 5'h00);
   endtask

   initial begin
      checks    = 0;
      failures  = 0;
      mon_en    = 1'b0;
      nrst      = 1'b0;
      bus8.load = 1'b1;
      bus8.din  = 8'hFF;
      bus5.load = 1'b1;
      bus5.din  = 5'h1F;
      @(posedge clk);
      #1;
      mon_en = 1'b1;

      // Reset held two cycles with load asserted; nothing may be captured.
      drive(1'b0, 1'b1, 8'hFF, 1'b1, 5'h1F);
      idle(3);

      // Single word on both instances.
      drive(1'b1, 1'b1, 8'b1010_1000, 1'b1, 5'b10101);
      idle(10);

      // Back-to-back: second word presented exactly on the last bit.
      drive(1'b1, 1'b1, 8'hA5, 1'b0, 5'h00);
      repeat (7) drive(1'b1, 1'b0, 8'h3C, 1'b0, 5'h00);
      drive(1'b1, 1'b1, 8'h3C, 1'b0, 5'h00);
      idle(18);

      // Busy load while cnt==3 is dropped.
      drive(1'b1, 1'b1, 8'h00, 1'b0, 5'h00);
      idle(3);
      drive(1'b1, 1'b1, 8'hFF, 1'b0, 5'h00);
      idle(12);

      // Reset at cnt==4, then a fresh word.
      drive(1'b1, 1'b1, 8'hAA, 1'b0, 5'h00);
      idle(4);
      drive(1'b0, 1'b0, 8'h00, 1'b0, 5'h00);
      drive(1'b1, 1'b1, 8'h81, 1'b0, 5'h00);
      idle(10);

      // Random loads, data and occasional resets.
      repeat (400) begin
         drive(($urandom_range(0, 59) != 0),
               ($urandom_range(0, 2) == 0), 8'($urandom),
               ($urandom_range(0, 2) == 0), 5'($urandom));
      end
      idle(20);

      check("dut8_drained", (exp8_q.size() == 0), 1'b1);
      check("dut5_drained", (exp5_q.size() == 0), 1'b1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
